// File: rtl/jt6295_rom_resp_if.sv
// ROM-port bundle between the ADPCM slot arbiter, the byte responder and the
// 16-bit memory controller. The responder uses the slave view; the
// surrounding system (arbiter plus memory controller) uses the master view.
interface jt6295_rom_resp_if #(
   parameter int AW = 18
);
   logic [AW-1:0] rom_addr;
   logic [7:0]    rom_data;
   logic          rom_ok;
   logic          flush;
   logic [AW-2:0] mem_addr;
   logic          mem_req;
   logic          mem_ack;
   logic [15:0]   mem_data;

   modport master (
      output rom_addr, flush, mem_ack, mem_data,
      input  rom_data, rom_ok, mem_addr, mem_req
   );

   modport slave (
      input  rom_addr, flush, mem_ack, mem_data,
      output rom_data, rom_ok, mem_addr, mem_req
   );
endinterface

// File: rtl/jt6295_rom_resp.sv
// ADPCM ROM byte responder: a current-word buffer plus a prefetched next-word
// buffer in front of a 16-bit req/ack memory port. Hits are resolved
// combinationally against the live byte address.
module jt6295_rom_resp #(
   parameter int AW       = 18,
   parameter bit PREFETCH = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   jt6295_rom_resp_if.slave bus
);
   localparam int TW = AW - 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DFETCH = 2'd1;
   localparam logic [1:0] ST_PFETCH = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [TW-1:0] mem_addr_q, mem_addr_d;
   logic          mem_req_q, mem_req_d;
   logic [TW-1:0] cur_tag_q, cur_tag_d;
   logic [15:0]   cur_data_q, cur_data_d;
   logic          cur_vld_q, cur_vld_d;
   logic [TW-1:0] nxt_tag_q, nxt_tag_d;
   logic [15:0]   nxt_data_q, nxt_data_d;
   logic          nxt_vld_q, nxt_vld_d;
   logic [7:0]    last_q, last_d;
   logic          discard_q, discard_d;

   logic [TW-1:0] tag;
   logic          hit_cur;
   logic          hit_nxt;
   logic [7:0]    byte_out;
   logic          ack;
   logic          nxt_has_pf;

   function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic sel);
      return sel ? w[15:8] : w[7:0];
   endfunction

   // Hit detection and byte selection against the live address; on a miss
   // the last returned byte is held.
   always_comb begin
      tag     = bus.rom_addr[AW-1:1];
      hit_cur = cur_vld_q && (cur_tag_q == tag);
      hit_nxt = nxt_vld_q && (nxt_tag_q == tag) && !hit_cur;
      if (hit_cur)
         byte_out = pick_byte(cur_data_q, bus.rom_addr[0]);
      else if (hit_nxt)
         byte_out = pick_byte(nxt_data_q, bus.rom_addr[0]);
      else
         byte_out = last_q;
   end

   assign bus.rom_ok   = hit_cur | hit_nxt;
   assign bus.rom_data = byte_out;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_req  = mem_req_q;

   // Fetch FSM: promotion, demand fills, prefetch fills and flush handling.
   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      mem_req_d  = mem_req_q;
      cur_tag_d  = cur_tag_q;
      cur_data_d = cur_data_q;
      cur_vld_d  = cur_vld_q;
      nxt_tag_d  = nxt_tag_q;
      nxt_data_d = nxt_data_q;
      nxt_vld_d  = nxt_vld_q;
      last_d     = byte_out;
      discard_d  = discard_q;
      ack        = mem_req_q && bus.mem_ack;
      nxt_has_pf = nxt_vld_q && (nxt_tag_q == mem_addr_q + TW'(1));

      case (state_q)
         ST_IDLE: begin
            discard_d = 1'b0;
            if (bus.flush) begin
               // Buffers are cleared below; the miss is taken next cycle.
               state_d = ST_IDLE;
            end else if (hit_nxt) begin
               cur_tag_d  = nxt_tag_q;
               cur_data_d = nxt_data_q;
               cur_vld_d  = 1'b1;
               nxt_vld_d  = 1'b0;
               if (PREFETCH) begin
                  state_d    = ST_PFETCH;
                  mem_addr_d = nxt_tag_q + TW'(1);
                  mem_req_d  = 1'b1;
               end
            end else if (!hit_cur) begin
               state_d    = ST_DFETCH;
               mem_addr_d = tag;
               mem_req_d  = 1'b1;
            end
         end

         ST_DFETCH, ST_PFETCH: begin
            if (ack) begin
               mem_req_d = 1'b0;
               discard_d = 1'b0;
               if (discard_q || bus.flush) begin
                  state_d = ST_IDLE;
               end else if (state_q == ST_DFETCH) begin
                  cur_tag_d  = mem_addr_q;
                  cur_data_d = bus.mem_data;
                  cur_vld_d  = 1'b1;
                  // Request stays low this cycle; PFETCH raises it next.
                  state_d    = (PREFETCH && !nxt_has_pf) ? ST_PFETCH : ST_IDLE;
               end else begin
                  nxt_tag_d  = mem_addr_q;
                  nxt_data_d = bus.mem_data;
                  nxt_vld_d  = 1'b1;
                  state_d    = ST_IDLE;
               end
            end else begin
               discard_d = discard_q | bus.flush;
               // Only reached right after a demand fill: fetch the following word.
               if (!mem_req_q) begin
                  mem_req_d  = 1'b1;
                  mem_addr_d = mem_addr_q + TW'(1);
               end
            end
         end

         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      if (bus.flush) begin
         cur_vld_d = 1'b0;
         nxt_vld_d = 1'b0;
      end
   end

   // State and buffer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         mem_addr_q <= '0;
         mem_req_q  <= 1'b0;
         cur_tag_q  <= '0;
         cur_data_q <= '0;
         cur_vld_q  <= 1'b0;
         nxt_tag_q  <= '0;
         nxt_data_q <= '0;
         nxt_vld_q  <= 1'b0;
         last_q     <= '0;
         discard_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         mem_req_q  <= mem_req_d;
         cur_tag_q  <= cur_tag_d;
         cur_data_q <= cur_data_d;
         cur_vld_q  <= cur_vld_d;
         nxt_tag_q  <= nxt_tag_d;
         nxt_data_q <= nxt_data_d;
         nxt_vld_q  <= nxt_vld_d;
         last_q     <= last_d;
         discard_q  <= discard_d;
      end
   end
endmodule
